// File: rtl/nios_pio_pkg.sv
// Shared constants for the Nios GPIO slave: register word addresses,
// edge-capture selector codes and the supported port width range.
package nios_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/nios_pio_sync.sv
// Multi-flop synchroniser for asynchronous pin inputs. Every stage resets
// to zero so the synchronised view of the pins starts low.
module nios_pio_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [SYNC_STAGES];

  // Shift the pin sample down the chain one stage per clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_chain[i] <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_chain[i] <= r_chain[i-1];
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/nios_system_gpio.sv
// Avalon-MM general-purpose I/O slave: output data register with atomic
// set/clear, per-bit direction, synchronised inputs and registered reads.
// Define NIOS_PIO_IRQ_EN to add edge capture, IRQMASK and the irq output;
// without it the irq port is tied low and addresses 2/3 read as zero.
module nios_system_gpio
  import nios_pio_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [31:0]      r_readdata;
  logic [WIDTH-1:0] w_in_sync;
  logic [WIDTH-1:0] w_wd;
  logic             w_wr;
  logic [31:0]      w_rd_val;
  logic             w_unused;

  assign w_wr = chipselect & ~write_n;
  assign w_wd = writedata[WIDTH-1:0];
  // Upper write-data bits beyond WIDTH and the edge selector (in builds
  // without capture) are intentionally not consumed.
  assign w_unused = ^{writedata, EDGE_TYPE[0]};

  nios_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (in_port),
    .o_q     (w_in_sync)
  );

  // Output data and direction registers; OUTSET/OUTCLR modify data in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RESET_OUT;
      r_dir      <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:   r_data_out <= w_wd;
        ADDR_DIR:    r_dir      <= w_wd;
        ADDR_OUTSET: r_data_out <= r_data_out | w_wd;
        ADDR_OUTCLR: r_data_out <= r_data_out & ~w_wd;
        default:     ;
      endcase
    end
  end

`ifdef NIOS_PIO_IRQ_EN
  logic [WIDTH-1:0] r_in_prev;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_cap_clr;

  // Edge detector selected at elaboration time.
  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  w_edge = w_in_sync & ~r_in_prev;
      EDGE_FALLING: w_edge = ~w_in_sync & r_in_prev;
      EDGE_ANY:     w_edge = w_in_sync ^ r_in_prev;
      default:      w_edge = w_in_sync & ~r_in_prev;
    endcase
  end

  assign w_cap_clr = (w_wr && address == ADDR_EDGECAP) ? w_wd : '0;

  // Previous-input, mask and sticky capture registers; a new edge beats a
  // clearing write on the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_prev <= '0;
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      r_in_prev <= w_in_sync;
      if (w_wr && address == ADDR_IRQMASK) r_irqmask <= w_wd;
      r_edgecap <= (r_edgecap & ~w_cap_clr) | w_edge;
    end
  end

  assign irq = |(r_edgecap & r_irqmask);
`else
  assign irq = 1'b0;
`endif

  // Read mux: pins for input bits, output register for output bits.
  always_comb begin
    w_rd_val = '0;
    case (address)
      ADDR_DATA:    w_rd_val[WIDTH-1:0] = (r_dir & r_data_out) | (~r_dir & w_in_sync);
      ADDR_DIR:     w_rd_val[WIDTH-1:0] = r_dir;
`ifdef NIOS_PIO_IRQ_EN
      ADDR_IRQMASK: w_rd_val[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: w_rd_val[WIDTH-1:0] = r_edgecap;
`endif
      default:      w_rd_val = '0;
    endcase
  end

  // Registered read data, refreshed every clock regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd_val;
  end

  assign readdata = r_readdata;
  assign out_port = r_data_out;
  assign out_en   = r_dir;

endmodule

// File: tb/tb_nios_system_gpio.sv
// Directed bench for nios_system_gpio (WIDTH=16, SYNC_STAGES=2, rising edge).
module tb_nios_system_gpio;

  localparam int          W      = 16;
  localparam logic [15:0] RST_OUT = 16'h00A5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] in_port;
  logic [W-1:0] out_port;
  logic [W-1:0] out_en;
  logic        irq;

  int errors = 0;
  int checks = 0;

  nios_system_gpio #(
    .WIDTH       (W),
    .RESET_OUT   (RST_OUT),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .out_en     (out_en),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address = a;
    tick();
    v = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = '0;
    repeat (3) tick();
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h exp 00000000", readdata); end
    reset_n = 1'b1;
    tick();
    checks++;
    if (out_port !== RST_OUT) begin errors++; $display("FAIL reset_out_port: got %h exp %h", out_port, RST_OUT); end
    checks++;
    if (out_en !== 16'h0) begin errors++; $display("FAIL reset_out_en: got %h exp 0000", out_en); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b exp 0", irq); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL reset_read_addr%0d: got %h exp 00000000", a, v); end
    end
  endtask

  task automatic test_set_clr();
    logic [31:0] v;
    wr(3'd0, 32'hFFFF_1234);
    checks++;
    if (out_port !== 16'h1234) begin errors++; $display("FAIL data_write: got %h exp 1234", out_port); end
    wr(3'd4, 32'h0000_00F0);
    checks++;
    if (out_port !== 16'h12F4) begin errors++; $display("FAIL outset: got %h exp 12F4", out_port); end
    wr(3'd5, 32'h0000_0204);
    checks++;
    if (out_port !== 16'h10F0) begin errors++; $display("FAIL outclr: got %h exp 10F0", out_port); end
    rd(3'd4, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL read_outset: got %h exp 00000000", v); end
    rd(3'd5, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL read_outclr: got %h exp 00000000", v); end
    wr(3'd7, 32'h0000_FFFF);
    checks++;
    if (out_port !== 16'h10F0 || out_en !== 16'h0) begin
      errors++; $display("FAIL write_addr7: out_port %h out_en %h exp 10F0 0000", out_port, out_en);
    end
  endtask

  task automatic test_dir_read();
    logic [31:0] v;
    wr(3'd1, 32'h0000_FF00);
    checks++;
    if (out_en !== 16'hFF00) begin errors++; $display("FAIL dir_out_en: got %h exp FF00", out_en); end
    wr(3'd0, 32'h0000_AB00);
    in_port = 16'h00CD;
    repeat (4) tick();
    rd(3'd1, v);
    checks++;
    if (v !== 32'h0000_FF00) begin errors++; $display("FAIL read_dir: got %h exp 0000FF00", v); end
    address = 3'd0;
    #1;
    checks++;
    if (readdata !== 32'h0000_FF00) begin errors++; $display("FAIL read_latency: got %h exp 0000FF00", readdata); end
    tick();
    checks++;
    if (readdata !== 32'h0000_ABCD) begin errors++; $display("FAIL read_data_mixed: got %h exp 0000ABCD", readdata); end
  endtask

  task automatic test_sync_latency();
    wr(3'd1, 32'h0);
    in_port = 16'h0000;
    address = 3'd0;
    repeat (4) tick();
    in_port = 16'h0004;
    tick();
    tick();
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL sync_early: got %h exp 00000000", readdata); end
    tick();
    checks++;
    if (readdata !== 32'h0000_0004) begin errors++; $display("FAIL sync_arrive: got %h exp 00000004", readdata); end
  endtask

`ifdef NIOS_PIO_IRQ_EN
  task automatic test_irq();
    logic [31:0] v;
    wr(3'd3, 32'h0000_FFFF);
    wr(3'd2, 32'h0000_0001);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b exp 0", irq); end
    in_port = 16'h0005;
    tick();
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b exp 0", irq); end
    tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b exp 1", irq); end
    rd(3'd3, v);
    checks++;
    if (v !== 32'h0000_0001) begin errors++; $display("FAIL edgecap_bit0: got %h exp 00000001", v); end
    wr(3'd3, 32'h0000_0001);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b exp 0", irq); end
    // bit3 rises so its capture lands on the same edge as a clearing write
    in_port = 16'h000D;
    tick();
    tick();
    wr(3'd3, 32'h0000_0008);
    rd(3'd3, v);
    checks++;
    if (v !== 32'h0000_0008) begin errors++; $display("FAIL set_beats_clear: got %h exp 00000008", v); end
    wr(3'd3, 32'h0000_0000);
    rd(3'd3, v);
    checks++;
    if (v !== 32'h0000_0008) begin errors++; $display("FAIL clear_zero_noop: got %h exp 00000008", v); end
    in_port = 16'h0005;
    repeat (4) tick();
    rd(3'd3, v);
    checks++;
    if (v !== 32'h0000_0008) begin errors++; $display("FAIL falling_ignored: got %h exp 00000008", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b exp 0", irq); end
    wr(3'd2, 32'h0000_0008);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmask: got %b exp 1", irq); end
    rd(3'd2, v);
    checks++;
    if (v !== 32'h0000_0008) begin errors++; $display("FAIL read_irqmask: got %h exp 00000008", v); end
  endtask
`else
  task automatic test_no_irq();
    logic [31:0] v;
    wr(3'd2, 32'h0000_FFFF);
    wr(3'd3, 32'h0000_FFFF);
    for (int i = 0; i < 8; i++) begin
      in_port = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL noirq_irq_cycle%0d: got %b exp 0", i, irq); end
    end
    rd(3'd2, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL noirq_read2: got %h exp 00000000", v); end
    rd(3'd3, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL noirq_read3: got %h exp 00000000", v); end
  endtask
`endif

  task automatic test_async_reset();
    logic [31:0] v;
    wr(3'd1, 32'h0000_0F0F);
    wr(3'd0, 32'h0000_5555);
    rd(3'd1, v);
    checks++;
    if (v !== 32'h0000_0F0F) begin errors++; $display("FAIL pre_reset_dir: got %h exp 00000F0F", v); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== RST_OUT) begin errors++; $display("FAIL async_out_port: got %h exp %h", out_port, RST_OUT); end
    checks++;
    if (out_en !== 16'h0) begin errors++; $display("FAIL async_out_en: got %h exp 0000", out_en); end
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL async_readdata: got %h exp 00000000", readdata); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_set_clr();
    test_dir_read();
    test_sync_latency();
`ifdef NIOS_PIO_IRQ_EN
    test_irq();
`else
    test_no_irq();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nios_system_gpio.md
# nios_system_gpio

Parametrised general-purpose I/O slave on the Nios system Avalon-MM bus. It generalises the fixed 16-bit in/out port:
- configurable width;
- per-bit direction register;
- atomic bit set/clear of the output register;
- synchronised inputs with edge capture and a maskable interrupt.

It sits between the system interconnect and board-level pins. Software drives it through a six-word register map.

## Interface
Parameters:
- WIDTH, 16, number of I/O bits (1..32)
- RESET_OUT, 0, reset value of the output data register (WIDTH bits)
- SYNC_STAGES, 2, input synchroniser depth (1..3)
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any

Ports:
- clk  in  1  system clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above WIDTH ignored
- readdata  out  32  registered read data, zero-extended
- in_port  in  WIDTH  asynchronous pin inputs
- out_port  out  WIDTH  output data register
- out_en  out  WIDTH  per-bit output enable (= direction register)
- irq  out  1  level interrupt (only with NIOS_PIO_IRQ_EN)

Reset is asynchronous and active-low on reset_n. All state is clocked by clk only.

## Operation
- Write occurs when chipselect=1 and write_n=0 at a clk rising edge.
- Register map:
  - 0 DATA
    - write: data_out <= writedata[WIDTH-1:0]
    - read: (dir & data_out) | (~dir & in_sync)
  - 1 DIR: read/write; 1 = output.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read returns capture bits. Writing 1 clears a bit; writing 0 leaves it unchanged.
  - 4 OUTSET: write-only; data_out <= data_out | wd. Reads 0.
  - 5 OUTCLR: write-only; data_out <= data_out & ~wd. Reads 0.
  - 6, 7: reads 0; writes ignored.
- readdata is updated every clock from the address, regardless of chipselect, with the read-mux value. Upper 32-WIDTH bits are 0.
- Input path:
  - in_port passes through a SYNC_STAGES flop chain to give in_sync.
  - in_prev <= in_sync every clock.
- Edge detection:
  - rising: in_sync & ~in_prev
  - falling: ~in_sync & in_prev
  - any: in_sync ^ in_prev
- EDGECAP bit sets on a detected edge and holds until cleared.
- If a set and a clearing write hit the same bit in the same cycle, the set wins.
- irq = |(edgecap & irqmask); combinational from registers, no additional flop.
- Edge detection runs on all bits regardless of DIR.
- After reset, in_prev=0. A pin already high therefore produces one rising capture SYNC_STAGES+1 clocks after reset. IRQMASK resets to 0, so software clears EDGECAP before unmasking.

## Timing
- Reset values:
  - out_port = RESET_OUT
  - out_en = 0
  - readdata = 0
  - irq = 0
  - irqmask = 0
  - edgecap = 0
  - sync chain and in_prev = 0
- Read latency: 1 clock. readdata at edge k+1 reflects address and state sampled at edge k.
- Writes take effect at the write edge and are visible on out_port/out_en immediately after it.
- Pin change to DATA read: in_sync reflects the change SYNC_STAGES edges after the first sampling edge. readdata shows it one edge later.
- Pin change to irq: edgecap sets SYNC_STAGES+1 edges after the first sampling edge. irq rises in the same cycle.
- Clearing write to EDGECAP: the bit is 0 after the write edge, and irq drops in the same cycle if no other masked bit is pending.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Nothing is retained.

## Configuration
- NIOS_PIO_IRQ_EN defined:
  - edge-capture logic, IRQMASK, EDGECAP and the irq output exist as above.
  - EDGE_TYPE applies.
- Not defined:
  - no in_prev, edgecap or irqmask registers.
  - addresses 2 and 3 read 0 and ignore writes.
  - irq port present, tied to 0.
  - EDGE_TYPE ignored.
  - The input synchroniser remains.

## Structure
- Package nios_pio_pkg:
  - address constants ADDR_DATA..ADDR_OUTCLR
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY constants
  - WIDTH range limits
- Sub-module nios_pio_sync: WIDTH-bit, SYNC_STAGES-deep flop chain with asynchronous active-low reset to 0.
- Top level contains the register file, read mux, and edge/irq logic.

## Test plan
- Reset, then read all 8 addresses -> every read returns 0x00000000; out_port=RESET_OUT; out_en=0; irq=0.
- Write DATA=0x1234, then OUTSET=0x00F0, then OUTCLR=0x0204 -> out_port 0x1234, then 0x12F4, then 0x10F0. Reads of 4 and 5 return 0.
- DIR=0xFF00, DATA=0xAB00, in_port=0x00CD -> DATA read returns 0xABCD one clock after the address is presented, once synchroniser latency has elapsed.
- EDGE_TYPE=0, IRQMASK=0x0001, in_port bit0 0->1 -> edgecap=0x0001 and irq=1 exactly SYNC_STAGES+1 edges later. Writing EDGECAP=0x0001 drops irq at the write edge.
- Rising edge on bit3 coincident with a clearing EDGECAP write of 0x0008 -> bit3 remains set.
- Build without NIOS_PIO_IRQ_EN, write IRQMASK=0xFFFF and toggle in_port -> address 2 reads 0 and irq stays 0 throughout.
